// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: channel-id width helper and mode encoding.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a channel index for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority request search starting at ptr and wrapping at N-1.
// Latency: combinational. Backpressure: none; qualified by the caller.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    always_comb begin : search
        int   j;
        logic found;
        grant       = '0;
        grant_valid = |req;
        found       = 1'b0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                grant = SELW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input stream mux, fixed-select or round-robin, into a single output register.
// Latency: 1 cycle, 1 word/cycle. Backpressure: in_ready drops while the held word is stalled.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               rr_en,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_grant;
    logic             rr_grant_valid;
    logic             fixed_valid;
    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [SELW-1:0]  ptr_next;

    rr_arbiter #(.N(N)) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    // A select value with no matching channel leaves fixed_valid low.
    always_comb begin
        fixed_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                fixed_valid = in_valid[i];
            end
        end
    end

    assign load        = ~out_valid | out_ready;
    assign grant       = (rr_en == MODE_RR) ? rr_grant : sel;
    assign grant_valid = (rr_en == MODE_RR) ? rr_grant_valid : fixed_valid;

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                in_ready[i] = load & grant_valid;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= grant;
                ptr       <= ptr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: vector table plus scoreboard queue, with reset and N=3 corner sequences.
module tb_stream_mux_n;

    typedef struct {
        logic        rr;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  rdy;
        logic [15:0] d2;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  ch;
    } word_t;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        rr_en;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
    logic [15:0] d4 [4];

    logic [2:0]  iv3;
    logic [47:0] data3;
    logic [2:0]  rdy3;
    logic [1:0]  sel3;
    logic        ov3;
    logic [15:0] od3;
    logic [1:0]  och3;
    logic        ordy3;

    int checks = 0;
    int errors = 0;
    word_t q[$];
    vec_t  vecs[$];

    assign in_data = {d4[3], d4[2], d4[1], d4[0]};
    assign data3   = {16'hA002, 16'hA001, 16'hA000};

    stream_mux_n #(.WIDTH(16), .N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sel(sel), .rr_en(rr_en), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
    );

    stream_mux_n #(.WIDTH(16), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_data(data3),
        .in_ready(rdy3), .sel(sel3), .rr_en(1'b0), .out_valid(ov3),
        .out_data(od3), .out_ch(och3), .out_ready(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rr, input logic [1:0] s, input logic [3:0] iv,
                                input logic ordy, input logic [3:0] rdy, input logic [15:0] d2);
        vec_t v;
        v.rr = rr; v.sel = s; v.iv = iv; v.ordy = ordy; v.rdy = rdy; v.d2 = d2;
        return v;
    endfunction

    // One cycle: drive, check combinational ready and the held word, then advance the scoreboard.
    task automatic run_vec(input vec_t v);
        word_t w;
        logic  exp_ov;
        @(negedge clk);
        rr_en = v.rr; sel = v.sel; in_valid = v.iv; out_ready = v.ordy; d4[2] = v.d2;
        #1;
        exp_ov = (q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(v.rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_data", 32'(out_data), 32'(q[0].d));
            chk("out_ch", 32'(out_ch), 32'(q[0].ch));
        end
        @(posedge clk);
        if (exp_ov && v.ordy) void'(q.pop_front());
        for (int i = 0; i < 4; i++) begin
            if (v.rdy[i]) begin
                w.ch = 2'(i);
                w.d  = d4[i];
                q.push_back(w);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; sel = '0; rr_en = 1'b0; out_ready = 1'b0;
        iv3 = '0; sel3 = '0; ordy3 = 1'b0;
        for (int i = 0; i < 4; i++) d4[i] = 16'h1000 + 16'(i);

        vecs.push_back(mk(0, 2, 4'b0100, 1, 4'b0100, 16'hBEEF));
        vecs.push_back(mk(0, 3, 4'b1000, 1, 4'b1000, 16'h1002));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 0, 4'b1111, 1, 4'(1 << (k % 4)), 16'h1002));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 0, 4'b1111, 0, 4'b0000, 16'h1002));
        vecs.push_back(mk(1, 0, 4'b1111, 1, 4'b0001, 16'h1002));
        vecs.push_back(mk(1, 0, 4'b1000, 1, 4'b1000, 16'h1002));
        vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b0001, 16'h1002));
        vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b1000, 16'h1002));
        vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b0001, 16'h1002));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 16'h1002));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 4'b0010, 16'h1002));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 4'b0000, 16'h1002));
        vecs.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 16'h1002));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 16'h1002));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Load a word with ptr moved off zero, then reset while it is held.
        run_vec(mk(0, 1, 4'b0010, 0, 4'b0010, 16'h1002));
        @(negedge clk);
        in_valid = '0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_ch", 32'(out_ch), 0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(1, 0, 4'b1111, 1, 4'b0001, 16'h1002));
        run_vec(mk(1, 0, 4'b1111, 1, 4'b0010, 16'h1002));
        run_vec(mk(1, 0, 4'b0000, 1, 4'b0000, 16'h1002));

        // Three-channel instance: out-of-range select never grants.
        @(negedge clk);
        sel3 = 2'd0; iv3 = 3'b111; ordy3 = 1'b1;
        #1;
        chk("n3_rdy_sel0", 32'(rdy3), 32'b001);
        @(negedge clk);
        sel3 = 2'd3;
        #1;
        chk("n3_rdy_sel3", 32'(rdy3), 0);
        chk("n3_out_valid_held", 32'(ov3), 1);
        chk("n3_out_data", 32'(od3), 32'hA000);
        chk("n3_out_ch", 32'(och3), 0);
        @(negedge clk);
        #1;
        chk("n3_out_valid_drained", 32'(ov3), 0);
        chk("n3_rdy_still0", 32'(rdy3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
